// File: rtl/ddr4_cal_rd_return.sv
`timescale 1ns/1ps
// Read-return scheduler: queues read CAS events, applies base plus per-rank latency
// with in-order clamping, and drives PHY FIFO read enables one cycle ahead of rdData.
module ddr4_cal_rd_return #(
    parameter int  DBYTES = 4,
    parameter int  DBAW   = 5,
    parameter int  RANKS  = 4,
    parameter int  DEPTH  = 16,
    parameter int  BEATS  = 1,
    parameter real TCQ    = 0.1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rdCAS,
    input  logic [1:0]           casRank,
    input  logic [DBAW-1:0]      casBuf,
    input  logic                 casInj,
    input  logic                 casRmw,
    input  logic [6:0]           max_rd_lat,
    input  logic [RANKS*3-1:0]   rank_lat_adj,
    input  logic                 clear,
    output logic [DBYTES-1:0]    fifo_rden_nxt,
    output logic                 rdDataEn,
    output logic [DBAW-1:0]      rdDataAddr,
    output logic                 rdDataEnd,
    output logic                 rdInj,
    output logic                 rdRmw,
    output logic                 busy,
    output logic                 overflow
);
    localparam int   AW     = $clog2(DEPTH);
    localparam logic LAST_K = (BEATS > 1);

    typedef enum logic {IDLE = 1'b0, BEAT = 1'b1} state_t;

    state_t          state;
    logic            beatIdx;
    logic [8:0]      cnt;
    logic [8:0]      lastDue;
    logic [AW-1:0]   rdPtr, wrPtr;
    logic [AW:0]     count, countNext;
    logic [DBAW-1:0] curBuf;
    logic            curInj, curRmw, rdenQ;

    logic [8:0]      dueMem [DEPTH];
    logic [DBAW-1:0] bufMem [DEPTH];
    logic            injMem [DEPTH];
    logic            rmwMem [DEPTH];

    logic [2:0] adjSel;
    logic [7:0] latRaw, lat;
    logic [8:0] dueRaw, dueMin, dueGap, dueNew;
    logic       lastValid, full, headHit, moreBeats, issueHead, issue, nextIdx, pop, push;

    // rdCAS is a one-cycle valid with no ready: a read that finds the queue full
    // with no pop in the same cycle is dropped and recorded in the sticky overflow.
    always_comb begin
        adjSel = rank_lat_adj[2:0];
        for (int r = 1; r < RANKS; r++) begin
            if (casRank == 2'(r)) adjSel = rank_lat_adj[r*3 +: 3];
        end
        latRaw    = {1'b0, max_rd_lat} + {5'b0, adjSel};
        lat       = (latRaw < 8'd3) ? 8'd3 : latRaw;
        dueRaw    = cnt + {1'b0, lat};
        dueMin    = lastDue + 9'(BEATS);
        dueGap    = dueRaw - dueMin;
        // lastDue is only meaningful while something is queued or bursting
        lastValid = (count != '0) || (state == BEAT);
        dueNew    = (lastValid && dueGap[8]) ? dueMin : dueRaw;

        // The FSM runs one cycle ahead of the data: BEAT covers the read-enable cycles
        headHit   = (count != '0) && ((dueMem[rdPtr] - 9'd2) == cnt);
        moreBeats = (state == BEAT) && (beatIdx != LAST_K);
        issueHead = !moreBeats && headHit;
        issue     = moreBeats || issueHead;
        nextIdx   = moreBeats ? (beatIdx + 1'b1) : 1'b0;
        pop       = issue && (nextIdx == LAST_K);
        full      = (count == (AW+1)'(DEPTH));
        push      = rdCAS && !clear && (!full || pop);
        countNext = count + (AW+1)'(push) - (AW+1)'(pop);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            dueMem[wrPtr] <= dueNew;
            bufMem[wrPtr] <= casBuf;
            injMem[wrPtr] <= casInj;
            rmwMem[wrPtr] <= casRmw;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            beatIdx    <= 1'b0;
            cnt        <= '0;
            lastDue    <= '0;
            rdPtr      <= '0;
            wrPtr      <= '0;
            count      <= '0;
            curBuf     <= '0;
            curInj     <= 1'b0;
            curRmw     <= 1'b0;
            rdenQ      <= 1'b0;
            rdDataEn   <= 1'b0;
            rdDataAddr <= '0;
            rdDataEnd  <= 1'b0;
            rdInj      <= 1'b0;
            rdRmw      <= 1'b0;
            busy       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            cnt <= cnt + 9'd1;
            if (clear) begin
                state      <= IDLE;
                beatIdx    <= 1'b0;
                rdPtr      <= '0;
                wrPtr      <= '0;
                count      <= '0;
                curBuf     <= '0;
                curInj     <= 1'b0;
                curRmw     <= 1'b0;
                rdenQ      <= 1'b0;
                rdDataEn   <= 1'b0;
                rdDataAddr <= '0;
                rdDataEnd  <= 1'b0;
                rdInj      <= 1'b0;
                rdRmw      <= 1'b0;
                busy       <= 1'b0;
                overflow   <= 1'b0;
            end else begin
                if (push) begin
                    wrPtr   <= wrPtr + 1'b1;
                    lastDue <= dueNew;
                end
                if (pop) rdPtr <= rdPtr + 1'b1;
                count <= countNext;
                if (rdCAS && full && !pop) overflow <= 1'b1;

                state   <= issue ? BEAT : IDLE;
                beatIdx <= nextIdx;
                rdenQ   <= issue;
                if (issueHead) begin
                    curBuf <= bufMem[rdPtr];
                    curInj <= injMem[rdPtr];
                    curRmw <= rmwMem[rdPtr];
                end

                rdDataEn   <= rdenQ;
                rdDataAddr <= rdenQ ? curBuf : '0;
                rdDataEnd  <= rdenQ && (beatIdx == LAST_K);
                rdInj      <= rdenQ && curInj;
                rdRmw      <= rdenQ && curRmw;
                busy       <= (countNext != '0) || issue || rdenQ;
            end
        end
    end

    assign fifo_rden_nxt = {DBYTES{rdenQ}};

endmodule

// File: tb/tb_ddr4_cal_rd_return.sv
`timescale 1ns/1ps
// Directed bench for ddr4_cal_rd_return: one single-beat and one two-beat instance
// share stimulus; each step checks hand-computed cycle-exact outputs.
module tb_ddr4_cal_rd_return;
  logic clk = 1'b0;
  logic rst_n;
  logic rdCAS, casInj, casRmw, clear;
  logic [1:0] casRank;
  logic [4:0] casBuf;
  logic [6:0] max_rd_lat;
  logic [11:0] rank_lat_adj;

  logic [3:0] u1_rden, u2_rden;
  logic u1_en, u1_end, u1_inj, u1_rmw, u1_busy, u1_ovf;
  logic u2_en, u2_end, u2_inj, u2_rmw, u2_busy, u2_ovf;
  logic [4:0] u1_addr, u2_addr;
  logic [10:0] u1v, u2v;
  logic [14:0] u1_all, u2_all;

  int n_checks = 0;
  int n_fail = 0;
  int since_rst = 0;
  int n1, n2, first1, exp_a, last_a;

  always #5 clk = ~clk;

  ddr4_cal_rd_return #(.BEATS(1)) u1 (
    .clk(clk), .rst_n(rst_n), .rdCAS(rdCAS), .casRank(casRank), .casBuf(casBuf),
    .casInj(casInj), .casRmw(casRmw), .max_rd_lat(max_rd_lat), .rank_lat_adj(rank_lat_adj),
    .clear(clear), .fifo_rden_nxt(u1_rden), .rdDataEn(u1_en), .rdDataAddr(u1_addr),
    .rdDataEnd(u1_end), .rdInj(u1_inj), .rdRmw(u1_rmw), .busy(u1_busy), .overflow(u1_ovf)
  );

  ddr4_cal_rd_return #(.BEATS(2)) u2 (
    .clk(clk), .rst_n(rst_n), .rdCAS(rdCAS), .casRank(casRank), .casBuf(casBuf),
    .casInj(casInj), .casRmw(casRmw), .max_rd_lat(max_rd_lat), .rank_lat_adj(rank_lat_adj),
    .clear(clear), .fifo_rden_nxt(u2_rden), .rdDataEn(u2_en), .rdDataAddr(u2_addr),
    .rdDataEnd(u2_end), .rdInj(u2_inj), .rdRmw(u2_rmw), .busy(u2_busy), .overflow(u2_ovf)
  );

  assign u1v = {u1_rden, u1_en, u1_end, u1_addr};
  assign u2v = {u2_rden, u2_en, u2_end, u2_addr};
  assign u1_all = {u1v, u1_inj, u1_rmw, u1_busy, u1_ovf};
  assign u2_all = {u2v, u2_inj, u2_rmw, u2_busy, u2_ovf};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    since_rst++;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic issue(input logic [1:0] rank, input logic [4:0] b, input logic inj, input logic rmw);
    rdCAS = 1'b1; casRank = rank; casBuf = b; casInj = inj; casRmw = rmw;
    tick();
    rdCAS = 1'b0; casInj = 1'b0; casRmw = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; rdCAS = 1'b0; casInj = 1'b0; casRmw = 1'b0; clear = 1'b0;
    casRank = 2'd0; casBuf = 5'd0; max_rd_lat = 7'd10; rank_lat_adj = 12'd0;
    step(3);
    check("reset_u1", u1_all, 15'd0);
    check("reset_u2", u2_all, 15'd0);
    rst_n = 1'b1;
    since_rst = 0;
    step(3);

    // single read, L=10
    issue(2'd0, 5'd3, 1'b1, 1'b0);
    check("single_busy", u1_busy, 1);
    step(7);
    check("single_t8", u1v, {4'h0, 1'b0, 1'b0, 5'd0});
    step(1);
    check("single_t9_rden", u1v, {4'hF, 1'b0, 1'b0, 5'd0});
    step(1);
    check("single_t10_data", u1v, {4'h0, 1'b1, 1'b1, 5'd3});
    check("single_t10_tags", {u1_inj, u1_rmw}, 2'b10);
    step(1);
    check("single_t11_idle", {u1v, u1_busy}, 12'd0);
    step(5);

    // rank adjust and in-order clamp
    rank_lat_adj = {3'd0, 3'd0, 3'd4, 3'd0};
    issue(2'd1, 5'd5, 1'b0, 1'b1);
    issue(2'd0, 5'd6, 1'b0, 1'b0);
    step(11);
    check("rank_t13", u1v, {4'hF, 1'b0, 1'b0, 5'd0});
    step(1);
    check("rank_t14", u1v, {4'hF, 1'b1, 1'b1, 5'd5});
    check("rank_t14_rmw", u1_rmw, 1);
    step(1);
    check("rank_t15_clamped", u1v, {4'h0, 1'b1, 1'b1, 5'd6});
    check("rank_t15_rmw", u1_rmw, 0);
    step(1);
    check("rank_t16", u1v, 11'd0);
    step(5);

    // two-beat mode, L=8, back-to-back
    rank_lat_adj = 12'd0;
    max_rd_lat = 7'd8;
    issue(2'd0, 5'd7, 1'b0, 1'b0);
    issue(2'd0, 5'd9, 1'b0, 1'b0);
    step(5);
    check("beat2_t7", u2v, {4'hF, 1'b0, 1'b0, 5'd0});
    step(1);
    check("beat2_t8", u2v, {4'hF, 1'b1, 1'b0, 5'd7});
    step(1);
    check("beat2_t9", u2v, {4'hF, 1'b1, 1'b1, 5'd7});
    step(1);
    check("beat2_t10", u2v, {4'hF, 1'b1, 1'b0, 5'd9});
    step(1);
    check("beat2_t11", u2v, {4'h0, 1'b1, 1'b1, 5'd9});
    step(1);
    check("beat2_t12", {u2v, u2_busy}, 12'd0);
    step(5);

    // full queue: 17 reads, L=100, no pops while filling
    max_rd_lat = 7'd100;
    for (int i = 0; i < 17; i++) begin
      if (i == 16) check("full_ovf_before", u1_ovf, 0);
      issue(2'd0, 5'(i), 1'b0, 1'b0);
    end
    check("full_ovf_u1", u1_ovf, 1);
    check("full_ovf_u2", u2_ovf, 1);
    n1 = 0; n2 = 0; first1 = -1; exp_a = 0;
    for (int c = 17; c < 140; c++) begin
      if (u1_en) begin
        if (first1 < 0) first1 = c;
        check("full_order", u1_addr, exp_a);
        exp_a++;
      end
      if (u1_end) n1++;
      if (u2_end) n2++;
      tick();
    end
    check("full_first_cycle", first1, 100);
    check("full_ends_u1", n1, 16);
    check("full_ends_u2", n2, 16);
    check("full_ovf_sticky", {u1_ovf, u2_ovf}, 2'b11);
    pulse_clear();
    check("full_clear_ovf", {u1_ovf, u2_ovf}, 2'b00);
    step(2);

    // full queue with a pop in the same cycle: accepted by BEATS=1, dropped by BEATS=2
    max_rd_lat = 7'd20;
    for (int i = 0; i < 16; i++) issue(2'd0, 5'(i), 1'b0, 1'b0);
    step(2);
    issue(2'd0, 5'd16, 1'b0, 1'b0);
    check("poppush_ovf_u1", u1_ovf, 0);
    check("poppush_ovf_u2", u2_ovf, 1);
    n1 = 0; last_a = -1;
    for (int c = 19; c < 60; c++) begin
      if (u1_end) begin
        n1++;
        last_a = u1_addr;
      end
      tick();
    end
    check("poppush_ends_u1", n1, 17);
    check("poppush_last_addr", last_a, 16);
    pulse_clear();
    step(2);

    // clear together with rdCAS while 4 reads are queued
    for (int i = 1; i < 5; i++) issue(2'd0, 5'(i), 1'b0, 1'b0);
    rdCAS = 1'b1; clear = 1'b1; casBuf = 5'd31;
    tick();
    rdCAS = 1'b0; clear = 1'b0;
    check("clear_busy", {u1_busy, u2_busy}, 2'b00);
    check("clear_ovf", {u1_ovf, u2_ovf}, 2'b00);
    n1 = 0; n2 = 0;
    for (int c = 0; c < 40; c++) begin
      if (u1_en) n1++;
      if (u2_en) n2++;
      tick();
    end
    check("clear_no_data", {n1[15:0], n2[15:0]}, 32'd0);

    // reset during a two-beat burst
    max_rd_lat = 7'd8;
    issue(2'd0, 5'd11, 1'b1, 1'b1);
    step(7);
    check("rst_burst_active", {u2v, u2_inj}, {4'hF, 1'b1, 1'b0, 5'd11, 1'b1});
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_u1", u1_all, 15'd0);
    check("rst_async_u2", u2_all, 15'd0);
    step(2);
    rst_n = 1'b1;
    since_rst = 0;
    n1 = 0; n2 = 0;
    for (int c = 0; c < 20; c++) begin
      if (u1_en || u1_rden != 4'h0) n1++;
      if (u2_en || u2_rden != 4'h0) n2++;
      tick();
    end
    check("rst_no_residual", {n1[15:0], n2[15:0]}, 32'd0);

    // counter wrap: L=134 (rank 2) at cnt=450, then L=127 clamped behind it
    max_rd_lat = 7'd127;
    rank_lat_adj = {3'd0, 3'd7, 3'd0, 3'd0};
    while (since_rst < 450) tick();
    issue(2'd2, 5'd21, 1'b0, 1'b0);
    issue(2'd0, 5'd22, 1'b0, 1'b0);
    step(131);
    check("wrap_t133", u1v, {4'hF, 1'b0, 1'b0, 5'd0});
    step(1);
    check("wrap_t134", u1v, {4'hF, 1'b1, 1'b1, 5'd21});
    check("wrap_t134_u2", u2v, {4'hF, 1'b1, 1'b0, 5'd21});
    step(1);
    check("wrap_t135", u1v, {4'h0, 1'b1, 1'b1, 5'd22});
    step(1);
    check("wrap_t136", u1v, 11'd0);
    step(5);

    // minimum latency clamp: L=1 behaves as 3
    max_rd_lat = 7'd1;
    rank_lat_adj = 12'd0;
    issue(2'd0, 5'd30, 1'b0, 1'b0);
    check("minlat_t1", u1v, 11'd0);
    step(1);
    check("minlat_t2", u1v, {4'hF, 1'b0, 1'b0, 5'd0});
    check("minlat_t2_u2", u2v, {4'hF, 1'b0, 1'b0, 5'd0});
    step(1);
    check("minlat_t3", u1v, {4'h0, 1'b1, 1'b1, 5'd30});
    check("minlat_t3_u2", u2v, {4'hF, 1'b1, 1'b0, 5'd30});
    step(1);
    check("minlat_t4_u2", u2v, {4'h0, 1'b1, 1'b1, 5'd30});
    step(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
